// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle RISC-V control unit.
//   state_t   : FSM states (also exported on state_dbg)
//   iclass_t  : instruction class produced by ctrl_decode
//   constants : opcode/funct fields, immediate-select, ALU-op, mux-select
//               and trap-cause codes
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    WB_ALU   = 4'd4,
    WB_IMM   = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    WB_MEM   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    BR_TAKEN = 4'd11,
    NEXT_PC  = 4'd12,
    TRAP     = 4'd13
  } state_t;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LD  = 3'd2,
    CLS_SD  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_LUI = 3'd5,
    CLS_ILL = 3'd6
  } iclass_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_LD_SD = 3'b011;
  localparam logic [2:0] F3_BEQ   = 3'b000;
  localparam logic [2:0] F3_BNE   = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [3:0] IMM_NONE = 4'd0;
  localparam logic [3:0] IMM_I    = 4'd1;
  localparam logic [3:0] IMM_B    = 4'd2;
  localparam logic [3:0] IMM_U    = 4'd3;
  localparam logic [3:0] IMM_S    = 4'd4;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam logic [1:0] WBS_ALU = 2'd0;
  localparam logic [1:0] WBS_MDR = 2'd1;
  localparam logic [1:0] WBS_IMM = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Handshake to the shared instruction/data memory.
//   mem_req      : request, held until mem_ready is sampled
//   mem_we       : 1 = write (meaningful only with mem_req)
//   mem_addr_sel : 0 = PC, 1 = ALUOut
//   mem_ready    : one-cycle completion pulse from memory
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, mem_we, mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier.
//   instr   : instruction-register contents
//   iclass  : instruction class (CLS_ILL for unsupported encodings)
//   illegal : 1 when iclass is CLS_ILL
//   imm_sel : immediate type implied by the opcode alone
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_t     iclass,
  output logic        illegal,
  output logic [3:0]  imm_sel
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    iclass  = CLS_ILL;
    imm_sel = IMM_NONE;
    case (opcode)
      OPC_OP: begin
        if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB))
          iclass = CLS_R;
      end
      OPC_OP_IMM: begin
        imm_sel = IMM_I;
        if (funct3 == F3_ADD) iclass = CLS_I;
      end
      OPC_LOAD: begin
        imm_sel = IMM_I;
        if (funct3 == F3_LD_SD) iclass = CLS_LD;
      end
      OPC_STORE: begin
        imm_sel = IMM_S;
        if (funct3 == F3_LD_SD) iclass = CLS_SD;
      end
      OPC_BRANCH: begin
        imm_sel = IMM_B;
        if (funct3 == F3_BEQ || funct3 == F3_BNE) iclass = CLS_BR;
      end
      OPC_LUI: begin
        imm_sel = IMM_U;
        iclass  = CLS_LUI;
      end
      default: ;
    endcase
  end

  assign illegal = (iclass == CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the 64-bit multicycle RISC-V datapath.
//   clk, reset   : rising-edge clock, asynchronous active-low reset
//   instr        : IR contents; alu_zero : ALU zero flag
//   mem          : memory handshake (master side)
//   ir_write, pc_write, pc_src, reg_write, wb_sel, alu_src_a, alu_src_b,
//   alu_op, imm_sel : datapath controls
//   trap, trap_cause : sticky trap indication; state_dbg : current state
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               alu_zero,
  multicycle_ctrl_if.master  mem,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic               reg_write,
  output logic [1:0]         wb_sel,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic [3:0]         imm_sel,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [3:0]         state_dbg
);

  state_t          state, state_next;
  logic            run;
  logic [TO_W-1:0] to_cnt;
  logic [3:0]      imm_q;
  logic [1:0]      cause_q, cause_next;

  iclass_t         iclass;
  logic            illegal;
  logic [3:0]      imm_dec;

  logic            waiting;
  logic            to_hit;
  logic            taken;
  logic            req, we, addr_sel;

  ctrl_decode u_decode (
    .instr   (instr),
    .iclass  (iclass),
    .illegal (illegal),
    .imm_sel (imm_dec)
  );

  // run holds off the first fetch request until one clock after reset
  // release, so every output is 0 while reset is asserted.
  assign waiting = run && (state inside {FETCH, MEM_RD, MEM_WR});
  // A ready pulse in the limit cycle takes priority over the timeout.
  assign to_hit  = waiting && !mem.mem_ready &&
                   (to_cnt == TO_W'(MEM_TIMEOUT - 1));
  assign taken   = ((instr[14:12] == F3_BEQ) &&  alu_zero) ||
                   ((instr[14:12] == F3_BNE) && !alu_zero);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      run     <= 1'b0;
      to_cnt  <= '0;
      imm_q   <= IMM_NONE;
      cause_q <= CAUSE_NONE;
    end else begin
      state   <= state_next;
      run     <= 1'b1;
      cause_q <= cause_next;
      if (state_next != state)
        to_cnt <= '0;
      else if (waiting && !mem.mem_ready)
        to_cnt <= to_cnt + TO_W'(1);
      if (state == DECODE)
        imm_q <= imm_dec;
      else if (state_next == FETCH)
        imm_q <= IMM_NONE;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause_q;
    req        = 1'b0;
    we         = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = WBS_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;

    case (state)
      FETCH: begin
        if (run) begin
          req = 1'b1;
          if (mem.mem_ready) begin
            ir_write   = 1'b1;
            state_next = DECODE;
          end else if (to_hit) begin
            state_next = TRAP;
            cause_next = CAUSE_TIMEOUT;
          end
        end
      end
      DECODE: begin
        // Branch target PC+imm is formed here, ahead of the compare.
        alu_src_b = SRCB_IMM;
        case (iclass)
          CLS_R:   state_next = EXEC_R;
          CLS_I:   state_next = EXEC_I;
          CLS_LD,
          CLS_SD:  state_next = MEM_ADDR;
          CLS_BR:  state_next = BRANCH;
          CLS_LUI: state_next = WB_IMM;
          default: state_next = TRAP;
        endcase
        if (illegal) cause_next = CAUSE_ILLEGAL;
      end
      EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = instr[30] ? ALU_SUB : ALU_ADD;
        state_next = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = WB_ALU;
      end
      WB_ALU, WB_IMM, WB_MEM: begin
        reg_write  = 1'b1;
        wb_sel     = (state == WB_ALU) ? WBS_ALU :
                     (state == WB_MEM) ? WBS_MDR : WBS_IMM;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = (iclass == CLS_LD) ? MEM_RD : MEM_WR;
      end
      MEM_RD, MEM_WR: begin
        req      = 1'b1;
        addr_sel = 1'b1;
        we       = (state == MEM_WR);
        if (mem.mem_ready) begin
          state_next = (state == MEM_RD) ? WB_MEM : NEXT_PC;
        end else if (to_hit) begin
          state_next = TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        state_next = taken ? BR_TAKEN : NEXT_PC;
      end
      BR_TAKEN: begin
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        state_next = FETCH;
      end
      NEXT_PC: begin
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      TRAP: ;
      default: state_next = FETCH;
    endcase
  end

  assign mem.mem_req      = req;
  assign mem.mem_we       = we;
  assign mem.mem_addr_sel = addr_sel;

  assign imm_sel    = (state == DECODE) ? imm_dec : imm_q;
  assign trap       = (state == TRAP);
  assign trap_cause = cause_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int TO = 4;

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_SD = 3, C_BR = 4, C_LUI = 5, C_ILL = 6;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] imm_sel;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] state_dbg;
  } out_t;

  typedef struct packed {
    logic        ready;
    logic        az;
    logic [31:0] ins;
    out_t        o;
  } step_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        alu_zero = 1'b0;
  logic        ir_write, pc_write, pc_src, reg_write, alu_src_a, trap;
  logic [1:0]  wb_sel, alu_src_b, trap_cause;
  logic [2:0]  alu_op;
  logic [3:0]  imm_sel, state_dbg;

  int checks = 0;
  int failures = 0;
  step_t q[$];

  multicycle_ctrl_if mif();

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .alu_zero   (alu_zero),
    .mem        (mif),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_sel    (imm_sel),
    .trap       (trap),
    .trap_cause (trap_cause),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.ir_write     = ir_write;
    o.pc_write     = pc_write;
    o.pc_src       = pc_src;
    o.mem_req      = mif.mem_req;
    o.mem_we       = mif.mem_we;
    o.mem_addr_sel = mif.mem_addr_sel;
    o.reg_write    = reg_write;
    o.wb_sel       = wb_sel;
    o.alu_src_a    = alu_src_a;
    o.alu_src_b    = alu_src_b;
    o.alu_op       = alu_op;
    o.imm_sel      = imm_sel;
    o.trap         = trap;
    o.trap_cause   = trap_cause;
    o.state_dbg    = state_dbg;
    return o;
  endfunction

  // Reference classification straight from the supported-instruction table.
  function automatic int ref_class(input logic [31:0] ins);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    if (op == 7'b0110011 && f3 == 3'd0 && (f7 == 7'd0 || f7 == 7'b0100000)) return C_R;
    if (op == 7'b0010011 && f3 == 3'd0) return C_I;
    if (op == 7'b0000011 && f3 == 3'd3) return C_LD;
    if (op == 7'b0100011 && f3 == 3'd3) return C_SD;
    if (op == 7'b1100011 && (f3 == 3'd0 || f3 == 3'd1)) return C_BR;
    if (op == 7'b0110111) return C_LUI;
    return C_ILL;
  endfunction

  function automatic logic [3:0] ref_imm(input logic [6:0] op);
    case (op)
      7'b0010011, 7'b0000011: return 4'd1;
      7'b1100011:             return 4'd2;
      7'b0110111:             return 4'd3;
      7'b0100011:             return 4'd4;
      default:                return 4'd0;
    endcase
  endfunction

  function automatic out_t blank(input logic [3:0] st);
    out_t o = '0;
    o.state_dbg = st;
    return o;
  endfunction

  function automatic out_t pc4(input out_t o_in);
    out_t o = o_in;
    o.alu_src_a = 1'b0;
    o.alu_src_b = 2'd1;
    o.alu_op    = 3'd0;
    o.pc_write  = 1'b1;
    o.pc_src    = 1'b0;
    return o;
  endfunction

  task automatic push(input logic rdy, input logic az, input logic [31:0] ins, input out_t o);
    step_t s;
    s.ready = rdy;
    s.az    = az;
    s.ins   = ins;
    s.o     = o;
    q.push_back(s);
  endtask

  task automatic trap_tail(input logic [1:0] cause, input logic [3:0] imm, input logic [31:0] ins);
    out_t o;
    for (int k = 0; k < 3; k++) begin
      o = blank(TRAP);
      o.trap       = 1'b1;
      o.trap_cause = cause;
      o.imm_sel    = imm;
      push(1'($urandom_range(0, 1)), 1'b0, ins, o);
    end
  endtask

  // Builds the expected cycle-by-cycle trace of one instruction, together
  // with the inputs to apply in each cycle.
  task automatic gen(input logic [31:0] ins, input int df, input int dm, input logic az,
                     output bit trapped);
    int         cls = ref_class(ins);
    logic [3:0] imm = ref_imm(ins[6:0]);
    out_t       o;
    bit         tk;
    trapped = 1'b0;
    for (int k = 0; k < df && k < TO; k++) begin
      o = blank(FETCH); o.mem_req = 1'b1;
      push(1'b0, az, ins, o);
    end
    if (df >= TO) begin
      trap_tail(2'd2, 4'd0, ins);
      trapped = 1'b1;
      return;
    end
    o = blank(FETCH); o.mem_req = 1'b1; o.ir_write = 1'b1;
    push(1'b1, az, ins, o);
    o = blank(DECODE); o.alu_src_b = 2'd2; o.imm_sel = imm;
    push(1'($urandom_range(0, 1)), az, ins, o);
    case (cls)
      C_R, C_I: begin
        o = blank(cls == C_R ? EXEC_R : EXEC_I);
        o.alu_src_a = 1'b1;
        o.alu_src_b = (cls == C_R) ? 2'd0 : 2'd2;
        o.alu_op    = (cls == C_R && ins[31:25] == 7'b0100000) ? 3'd1 : 3'd0;
        o.imm_sel   = imm;
        push(1'($urandom_range(0, 1)), az, ins, o);
        o = pc4(blank(WB_ALU)); o.reg_write = 1'b1; o.wb_sel = 2'd0; o.imm_sel = imm;
        push(1'($urandom_range(0, 1)), az, ins, o);
      end
      C_LUI: begin
        o = pc4(blank(WB_IMM)); o.reg_write = 1'b1; o.wb_sel = 2'd2; o.imm_sel = imm;
        push(1'($urandom_range(0, 1)), az, ins, o);
      end
      C_BR: begin
        o = blank(BRANCH); o.alu_src_a = 1'b1; o.alu_op = 3'd1; o.imm_sel = imm;
        push(1'($urandom_range(0, 1)), az, ins, o);
        tk = (ins[14:12] == 3'd0) ? az : !az;
        if (tk) begin
          o = blank(BR_TAKEN); o.pc_write = 1'b1; o.pc_src = 1'b1;
        end else begin
          o = pc4(blank(NEXT_PC));
        end
        o.imm_sel = imm;
        push(1'($urandom_range(0, 1)), az, ins, o);
      end
      C_LD, C_SD: begin
        o = blank(MEM_ADDR); o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.imm_sel = imm;
        push(1'($urandom_range(0, 1)), az, ins, o);
        o = blank(cls == C_LD ? MEM_RD : MEM_WR);
        o.mem_req = 1'b1; o.mem_addr_sel = 1'b1; o.mem_we = (cls == C_SD); o.imm_sel = imm;
        for (int k = 0; k < dm && k < TO; k++) push(1'b0, az, ins, o);
        if (dm >= TO) begin
          trap_tail(2'd2, imm, ins);
          trapped = 1'b1;
          return;
        end
        push(1'b1, az, ins, o);
        if (cls == C_LD) begin
          o = pc4(blank(WB_MEM)); o.reg_write = 1'b1; o.wb_sel = 2'd1;
        end else begin
          o = pc4(blank(NEXT_PC));
        end
        o.imm_sel = imm;
        push(1'($urandom_range(0, 1)), az, ins, o);
      end
      default: begin
        trap_tail(2'd1, imm, ins);
        trapped = 1'b1;
      end
    endcase
  endtask

  task automatic run_q(input int n);
    int    cnt = 0;
    step_t s;
    while (q.size() > 0 && (n < 0 || cnt < n)) begin
      s = q.pop_front();
      @(posedge clk);
      #1;
      mif.mem_ready = s.ready;
      alu_zero      = s.az;
      instr         = s.ins;
      @(negedge clk);
      check($sformatf("ins=%h st=%0d", s.ins, s.o.state_dbg), 32'(sample()), 32'(s.o));
      cnt++;
    end
    q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mif.mem_ready = 1'b0;
    #1;
    check("reset_async", 32'(sample()), 32'd0);
    mif.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", 32'(sample()), 32'd0);
    mif.mem_ready = 1'b0;
    reset = 1'b1;
  endtask

  task automatic episode(input logic [31:0] ins, input int df, input int dm, input logic az);
    bit tr;
    gen(ins, df, dm, az, tr);
    run_q(-1);
    if (tr) do_reset();
  endtask

  function automatic logic [31:0] mk_ins(input int k);
    logic [31:0] r = $urandom;
    case (k)
      0: begin r[6:0] = 7'b0110011; r[14:12] = 3'd0; r[31:25] = 7'b0000000; end
      1: begin r[6:0] = 7'b0110011; r[14:12] = 3'd0; r[31:25] = 7'b0100000; end
      2: begin r[6:0] = 7'b0010011; r[14:12] = 3'd0; end
      3: begin r[6:0] = 7'b0000011; r[14:12] = 3'd3; end
      4: begin r[6:0] = 7'b0100011; r[14:12] = 3'd3; end
      5: begin r[6:0] = 7'b1100011; r[14:12] = 3'd0; end
      6: begin r[6:0] = 7'b1100011; r[14:12] = 3'd1; end
      7: r[6:0] = 7'b0110111;
      8: r[6:0] = 7'h7F;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    bit tr;
    int r, df, dm;
    mif.mem_ready = 1'b0;
    do_reset();

    episode(32'h00500093, 0, 0, 1'b0);   // ADDI
    episode(32'h00208463, 0, 0, 1'b1);   // BEQ taken
    episode(32'h00208463, 0, 0, 1'b0);   // BEQ not taken
    episode(32'h0000B103, 0, 3, 1'b0);   // LD, ready delayed 3
    episode(32'h0020B023, 1, 0, 1'b0);   // SD
    episode(32'h000120B7, 0, 0, 1'b0);   // LUI
    episode(32'h40208033, 2, 0, 1'b0);   // SUB
    episode(32'h0000007F, 0, 0, 1'b0);   // illegal -> trap cause 1
    episode(32'h00500093, TO, 0, 1'b0);  // fetch timeout -> cause 2
    episode(32'h00500093, TO - 1, 0, 1'b0); // ready on limit cycle completes
    episode(32'h0000B103, 0, TO, 1'b0);  // load timeout
    episode(32'h0020B023, 0, TO - 1, 1'b0);

    // Asynchronous reset while a store request is outstanding.
    gen(32'h0020B023, 0, 3, 1'b0, tr);
    run_q(4);
    @(posedge clk);
    #1;
    check("memwr_req_before_rst", 32'(mif.mem_req), 32'd1);
    do_reset();
    episode(32'h00500093, 0, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      r  = $urandom_range(0, 19);
      df = (r == 0) ? TO : r % 4;
      r  = $urandom_range(0, 19);
      dm = (r == 0) ? TO : r % 4;
      episode(mk_ins($urandom_range(0, 9)), df, dm, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore FSM control unit for the 64-bit multicycle RISC-V datapath. It sequences instruction fetch, decode, execute, memory access and writeback, and drives the datapath select lines. These include the SignExtend immediate-type select and a timed handshake to the shared instruction/data memory. It supports ADD, SUB, ADDI, LD, SD, BEQ, BNE and LUI. Any other encoding traps.

Parameters:
MEM_TIMEOUT, 255, maximum wait cycles for mem_ready before trapping (1..65535)
TO_W, 16, width of the timeout counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
instr  in  32  current instruction-register contents
alu_zero  in  1  ALU zero flag
mem_ready  in  1  memory completion, one-cycle pulse
ir_write  out  1  load the IR
pc_write  out  1  load the PC
pc_src  out  1  0 = ALU result, 1 = ALUOut (branch target)
mem_req  out  1  memory request
mem_we  out  1  1 = write (valid only with mem_req)
mem_addr_sel  out  1  0 = PC, 1 = ALUOut
reg_write  out  1  register-file write enable
wb_sel  out  2  0 = ALUOut, 1 = MDR, 2 = immediate
alu_src_a  out  1  0 = PC, 1 = rs1
alu_src_b  out  2  0 = rs2, 1 = constant 4, 2 = immediate
alu_op  out  3  0 = ADD, 1 = SUB, others reserved
imm_sel  out  4  0 = none, 1 = I, 2 = B, 3 = U, 4 = S
trap  out  1  sticky trap flag
trap_cause  out  2  0 = none, 1 = illegal instruction, 2 = memory timeout
state_dbg  out  4  current state encoding

Behaviour:
- Reset (asserted, any cycle, including mid-handshake): state = FETCH. All outputs are 0 except mem_req, which rises in the first cycle after release. The timeout counter and imm_sel register clear.
- Outputs are decoded from the state register, except the branch-taken decision in BRANCH.
- imm_sel register:
  - Loaded in DECODE from the opcode.
  - Held until the instruction retires.
  - 0 during FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0. Hold until mem_ready. In the mem_ready cycle assert ir_write=1, then go to DECODE.
- DECODE: one cycle. Classify by opcode, funct3 and funct7:
  - 0110011, f3 000, f7 0000000 or 0100000 -> EXEC_R
  - 0010011, f3 000 -> EXEC_I
  - 0000011 or 0100011, f3 011 -> MEM_ADDR
  - 1100011, f3 000 or 001 -> BRANCH
  - 0110111 -> WB_IMM
  - anything else -> TRAP, cause 1
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=ADD or SUB (from f7[5]). Next: WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=2, ADD. Next: WB_ALU.
- WB_ALU: reg_write=1, wb_sel=0. PC update in the same cycle: alu_src_a=0, alu_src_b=1, ADD, pc_write=1, pc_src=0. Next: FETCH.
- WB_IMM: reg_write=1, wb_sel=2, plus the same PC+4 update. Next: FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD. Next: MEM_RD (LD) or MEM_WR (SD).
- MEM_RD: mem_req=1, mem_addr_sel=1, mem_we=0. On mem_ready go to WB_MEM.
- WB_MEM: reg_write=1, wb_sel=1, plus PC+4 update. Next: FETCH.
- MEM_WR: mem_req=1, mem_we=1, mem_addr_sel=1. On mem_ready go to NEXT_PC.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, SUB.
  - taken = (f3=000 & alu_zero) | (f3=001 & !alu_zero).
  - Taken -> BR_TAKEN, else NEXT_PC.
  - Branch target is PC+imm, computed into ALUOut during DECODE: alu_src_a=0, alu_src_b=2, ADD, imm_sel already valid combinationally in DECODE.
- BR_TAKEN: pc_write=1, pc_src=1. Next: FETCH.
- NEXT_PC: PC+4 update. Next: FETCH.
- TRAP: terminal until reset. trap=1, cause held, all enables 0.
- Handshake rules:
  - Once raised, mem_req stays high until mem_ready is sampled.
  - mem_addr_sel and mem_we are stable while mem_req is high.
  - mem_ready while mem_req=0 is ignored.
- Timeout counter:
  - Increments each cycle in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - Clears on state exit.
  - Reaching MEM_TIMEOUT goes to TRAP with cause 2, and mem_req drops the next cycle.
  - mem_ready in the same cycle as the limit is reached wins: normal completion.
- Zero-wait latencies: R/I-type 4 cycles, LUI 3, branch 4, LD 5, SD 5.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - state_t enum (4-bit)
  - opcode, funct3 and funct7 constants
  - imm_sel codes (IMM_NONE/I/B/U/S)
  - alu_op codes
  - trap_cause codes
- Sub-module ctrl_decode: combinational instruction classifier that outputs the instruction class and illegal flag. The FSM stays in multicycle_ctrl.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready on the first cycle -> ir_write cycle 1, imm_sel=1 in DECODE, reg_write+pc_write together in cycle 4, back to FETCH.
- BEQ (0x00208463) with alu_zero=1 in BRANCH -> pc_src=1, pc_write in cycle 4. Repeat with alu_zero=0 -> NEXT_PC, pc_src=0.
- LD (0x0000B103) with mem_ready delayed 3 cycles in MEM_RD -> mem_req held 4 cycles, addr_sel=1, mem_we=0, WB_MEM wb_sel=1.
- Opcode 0x0000007F -> TRAP, trap=1, trap_cause=1. Further mem_ready pulses are ignored; reset returns to FETCH.
- MEM_TIMEOUT=4, mem_ready never asserted in FETCH -> TRAP with cause 2 after 4 wait cycles. Also: mem_ready on the 4th cycle -> normal completion.
- Reset asserted during MEM_WR with mem_req high -> mem_req=0 immediately (asynchronous), state_dbg=FETCH, imm_sel=0.
